// File: rtl/program_memory_pkg.sv
// Shared definitions for the program memory: FSM state encoding and the NOP opcode
// that fills the top bits of NOP_WORD.
package program_memory_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } pm_state_t;

  localparam int OPCODE_W = 4;
  localparam logic [OPCODE_W-1:0] NOP_OPCODE = 4'hF;

endpackage

// File: rtl/program_memory_if.sv
// Fetch and load bus of the program memory; the processor/loader side drives it
// through the master modport and the memory receives it through the slave modport.
interface program_memory_if #(
  parameter int DATA_WIDTH = 28,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] iAddress;
  logic                  iFetch;
  logic [DATA_WIDTH-1:0] oInstruction;
  logic                  oValid;
  logic                  iLoadStart;
  logic                  iLoadWrite;
  logic [DATA_WIDTH-1:0] iLoadData;
  logic                  iLoadDone;
  logic                  oLoading;
  logic [ADDR_WIDTH:0]   oLoadCount;
  logic                  oOverflow;

  modport master (
    output iAddress, iFetch, iLoadStart, iLoadWrite, iLoadData, iLoadDone,
    input  oInstruction, oValid, oLoading, oLoadCount, oOverflow
  );

  modport slave (
    input  iAddress, iFetch, iLoadStart, iLoadWrite, iLoadData, iLoadDone,
    output oInstruction, oValid, oLoading, oLoadCount, oOverflow
  );
endinterface

// File: rtl/prog_mem_loader.sv
// Load FSM: tracks IDLE/LOAD/RUN, owns the write pointer (which doubles as the
// load count) and the sticky overflow flag, and issues word write enables.
module prog_mem_loader
  import program_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 256
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                load_start,
  input  logic                load_write,
  input  logic                load_done,
  input  logic                fetch,
  output pm_state_t           state,
  output logic                loading,
  output logic [ADDR_WIDTH:0] load_count,
  output logic                overflow,
  output logic                wr_en,
  output logic                clr_flags
);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);

  logic full;

  assign full = (load_count == DEPTH_L);
  // Every state enters (or restarts) LOAD on load_start, so it alone clears the flags.
  assign clr_flags = load_start;
  assign wr_en     = Reset && (state == ST_LOAD) && load_write && !load_start && !full;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state      <= ST_IDLE;
      loading    <= 1'b0;
      load_count <= '0;
      overflow   <= 1'b0;
    end else if (load_start) begin
      state      <= ST_LOAD;
      loading    <= 1'b1;
      load_count <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fetch) state <= ST_RUN;
        end
        ST_LOAD: begin
          if (load_write) begin
            if (full) overflow   <= 1'b1;
            else      load_count <= load_count + ONE;
          end
          if (load_done) begin
            state   <= ST_RUN;
            loading <= 1'b0;
          end
        end
        ST_RUN: ;
        default: begin
          state   <= ST_IDLE;
          loading <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/program_memory.sv
// Program memory: storage array with per-word written flags and a one-cycle fetch
// path; unwritten, out-of-range or mid-load fetches return NOP_WORD.
module program_memory
  import program_memory_pkg::*;
#(
  parameter int DATA_WIDTH = 28,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 256
) (
  input logic              Clock,
  input logic              Reset,
  program_memory_if.slave  bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] NOP_WORD = {NOP_OPCODE, {(DATA_WIDTH-OPCODE_W){1'b0}}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      written;

  pm_state_t             state;
  logic                  loading;
  logic [ADDR_WIDTH:0]   load_count;
  logic                  overflow;
  logic                  wr_en;
  logic                  clr_flags;
  logic [IDX_W-1:0]      wr_idx;

  prog_mem_loader #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_loader (
    .Clock      (Clock),
    .Reset      (Reset),
    .load_start (bus.iLoadStart),
    .load_write (bus.iLoadWrite),
    .load_done  (bus.iLoadDone),
    .fetch      (bus.iFetch),
    .state      (state),
    .loading    (loading),
    .load_count (load_count),
    .overflow   (overflow),
    .wr_en      (wr_en),
    .clr_flags  (clr_flags)
  );

  assign wr_idx = load_count[IDX_W-1:0];

  always_ff @(posedge Clock) begin
    if (wr_en) mem[wr_idx] <= bus.iLoadData;
  end

  // Array contents are never cleared; clearing the flags is what hides stale words.
  always_ff @(posedge Clock) begin
    if (!Reset || clr_flags) written <= '0;
    else if (wr_en)          written[wr_idx] <= 1'b1;
  end

  // Stage p0: fetch address decode
  logic [IDX_W-1:0] rd_idx_p0;
  logic             hit_p0;

  assign rd_idx_p0 = bus.iAddress[IDX_W-1:0];
  assign hit_p0    = ({1'b0, bus.iAddress} < DEPTH_L) && written[rd_idx_p0] &&
                     (state != ST_LOAD);

  // Stage p1: registered fetch result
  logic [DATA_WIDTH-1:0] instr_p1;
  logic                  vld_p1;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      vld_p1   <= 1'b0;
      instr_p1 <= NOP_WORD;
    end else begin
      vld_p1 <= bus.iFetch;
      if (bus.iFetch) instr_p1 <= hit_p0 ? mem[rd_idx_p0] : NOP_WORD;
    end
  end

  assign bus.oInstruction = instr_p1;
  assign bus.oValid       = vld_p1;
  assign bus.oLoading     = loading;
  assign bus.oLoadCount   = load_count;
  assign bus.oOverflow    = overflow;
endmodule

// File: doc/program_memory.md
PROGRAM_MEMORY -- requirements
Module: program_memory

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 28, instruction word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, fetch address width.
REQ-003 SHALL have parameter DEPTH, default 256, number of stored words; legal range 2..2^ADDR_WIDTH.
REQ-004 SHALL have port Clock  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-low reset, sampled on the Clock rising edge.
REQ-006 SHALL have port iAddress  input  ADDR_WIDTH  fetch address.
REQ-007 SHALL have port iFetch  input  1  fetch request, one word per asserted cycle.
REQ-008 SHALL have port oInstruction  output  DATA_WIDTH  fetched word.
REQ-009 SHALL have port oValid  output  1  oInstruction holds the result of a fetch.
REQ-010 SHALL have port iLoadStart  input  1  begin a program load.
REQ-011 SHALL have port iLoadWrite  input  1  iLoadData valid this cycle.
REQ-012 SHALL have port iLoadData  input  DATA_WIDTH  program word.
REQ-013 SHALL have port iLoadDone  input  1  end the program load.
REQ-014 SHALL have port oLoading  output  1  high while in LOAD state.
REQ-015 SHALL have port oLoadCount  output  ADDR_WIDTH+1  number of words written in the current or last load.
REQ-016 SHALL have port oOverflow  output  1  sticky flag, load attempted beyond DEPTH.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, RUN; reset enters IDLE.
REQ-018 SHALL transition IDLE->LOAD and RUN->LOAD on iLoadStart, LOAD->RUN on iLoadDone, and IDLE->RUN on iFetch.
REQ-019 SHALL, on entering LOAD, clear the write pointer, oLoadCount, oOverflow and all per-word written flags.
REQ-020 SHALL, in LOAD with iLoadWrite, write iLoadData at the write pointer, set that word's written flag, and increment the pointer and oLoadCount.
REQ-021 SHALL, when iLoadWrite arrives with pointer = DEPTH, discard the data, keep the pointer, and set oOverflow until the next load start.
REQ-022 SHALL give iLoadStart priority over iLoadDone when both are asserted; iLoadWrite in that cycle is ignored.
REQ-023 SHALL have read latency 1: iFetch at cycle N -> oInstruction and oValid at N+1; oValid is 0 in cycles after no fetch.
REQ-024 SHALL return NOP_WORD for a fetch when iAddress >= DEPTH, the word's written flag is 0, or the state is LOAD.
REQ-025 SHALL ignore iFetch in LOAD for data purposes (oValid=1, oInstruction=NOP_WORD) so the processor stalls on NOPs.
REQ-026 SHALL hold oInstruction at its last value while oValid=0.
REQ-027 SHALL retain memory contents and written flags across IDLE/RUN transitions.

Reset
REQ-028 SHALL, when Reset=0 at a clock edge, set state=IDLE, oInstruction=NOP_WORD, oValid=0, oLoading=0, oLoadCount=0, oOverflow=0, write pointer=0, and all written flags=0.
REQ-029 SHALL abort a load in progress on reset; words already written become unreadable through their cleared flags, and array contents are not cleared.
REQ-030 SHALL give reset priority over every other input.

Structure
REQ-031 SHALL take NOP_WORD ({NOP opcode, zeros}) and FSM state encodings from the shared definitions header.
REQ-032 SHALL place the load FSM, write pointer and overflow logic in sub-module prog_mem_loader; the storage array and read path stay in program_memory.

Verification
REQ-033 SHALL cover: reset, then iFetch at address 0 -> next cycle oValid=1 and oInstruction=NOP_WORD.
REQ-034 SHALL cover: load of 10 words 0x0000001..0x000000A, iLoadDone, then fetch addresses 0..9 -> matching words each at latency 1, with oLoadCount=10.
REQ-035 SHALL cover: DEPTH=4 with 6 words loaded -> oLoadCount=4, oOverflow=1, fetch address 3 returns word 4, and fetch address 4 returns NOP_WORD.
REQ-036 SHALL cover: fetch of an unwritten address 200 after a 10-word load -> NOP_WORD.
REQ-037 SHALL cover: Reset=0 after 3 loaded words during LOAD -> state IDLE, oLoading=0, and fetch address 0 returns NOP_WORD.
REQ-038 SHALL cover: iLoadStart and iLoadDone asserted in the same cycle from RUN -> state LOAD, oLoadCount=0, and oOverflow cleared.
